// File: rtl/t05_sd_block_reader.sv
`default_nettype none
// ============================================================================
// Module   : t05_sd_block_reader
// Purpose  : Frames SD multi-block read byte streams into a FWFT payload FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module t05_sd_block_reader #(
    parameter int         BLOCK_BYTES   = 512,
    parameter int         FIFO_DEPTH    = 8,
    parameter logic [7:0] TOKEN         = 8'hFE,
    parameter int         TOKEN_TIMEOUT = 255,
    parameter int         STOP_HOLD     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_blocks,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        read_en,
    output logic        read_stop,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] block_count
);

    localparam int c_BC_W   = $clog2(BLOCK_BYTES);
    localparam int c_TO_W   = $clog2(TOKEN_TIMEOUT + 1);
    localparam int c_STOP_W = $clog2(STOP_HOLD + 1);
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_AW + 1;

    localparam logic [c_BC_W-1:0]   c_LAST_BYTE = c_BC_W'(BLOCK_BYTES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TOKEN_TIMEOUT - 1);
    localparam logic [c_STOP_W-1:0] c_STOP_LAST = c_STOP_W'(STOP_HOLD - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_EN_MAX    = c_CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HUNT  = 3'd1,
        S_DATA  = 3'd2,
        S_CRC   = 3'd3,
        S_STOP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t               r_state;
    logic [15:0]          r_num_blocks;
    logic [15:0]          r_block_count;
    logic [c_BC_W-1:0]    r_byte_cnt;
    logic [c_TO_W-1:0]    r_timeout_cnt;
    logic [c_STOP_W-1:0]  r_stop_cnt;
    logic                 r_crc_cnt;
    logic                 r_read_en;
    logic                 r_read_stop;
    logic                 r_done;
    logic                 r_error;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_valid;
    logic                 w_overflow;
    logic [15:0]          w_bc_next;

    // A simultaneous pop frees the head slot, so a push into a full FIFO is still accepted.
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = w_valid && data_ready;
    assign w_push_req = (r_state == S_DATA) && byte_valid;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_overflow = w_push_req && w_full && !w_pop;
    assign w_bc_next  = (r_block_count == 16'hFFFF) ? r_block_count : r_block_count + 16'd1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_num_blocks  <= '0;
            r_block_count <= '0;
            r_byte_cnt    <= '0;
            r_timeout_cnt <= '0;
            r_stop_cnt    <= '0;
            r_crc_cnt     <= 1'b0;
            r_read_en     <= 1'b0;
            r_read_stop   <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_read_en <= ((r_state == S_HUNT) || (r_state == S_DATA) || (r_state == S_CRC))
                         && (r_count <= c_EN_MAX);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        if (num_blocks != 16'd0) begin
                            r_num_blocks  <= num_blocks;
                            r_block_count <= '0;
                            r_byte_cnt    <= '0;
                            r_timeout_cnt <= '0;
                            r_state       <= S_HUNT;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_HUNT: begin
                    if (byte_valid) begin
                        if (byte_in == TOKEN) begin
                            r_byte_cnt <= '0;
                            r_state    <= S_DATA;
                        end else if (r_timeout_cnt == c_TO_LAST) begin
                            r_error     <= 1'b1;
                            r_read_stop <= 1'b1;
                            r_stop_cnt  <= '0;
                            r_state     <= S_STOP;
                        end else begin
                            r_timeout_cnt <= r_timeout_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (byte_valid) begin
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            r_crc_cnt  <= 1'b0;
                            r_state    <= S_CRC;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                S_CRC: begin
                    if (byte_valid) begin
                        if (!r_crc_cnt) begin
                            r_crc_cnt <= 1'b1;
                        end else begin
                            r_block_count <= w_bc_next;
                            if (w_bc_next == r_num_blocks) begin
                                r_read_stop <= 1'b1;
                                r_stop_cnt  <= '0;
                                r_state     <= S_STOP;
                            end else begin
                                r_timeout_cnt <= '0;
                                r_state       <= S_HUNT;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (r_stop_cnt == c_STOP_LAST) begin
                        r_read_stop <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!w_valid) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_overflow) begin
                r_error <= 1'b1;
            end
        end
    end

    assign read_en     = r_read_en;
    assign read_stop   = r_read_stop;
    assign data_valid  = w_valid;
    assign data_out    = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign error       = r_error;
    assign block_count = r_block_count;

endmodule
`default_nettype wire

// File: tb/tb_t05_sd_block_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_t05_sd_block_reader
// Purpose  : Scoreboard bench for the SD block reader with randomized streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t05_sd_block_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_blocks = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        read_en;
    logic        read_stop;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] block_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          ready_pct = 100;
    int          done_cnt = 0;
    int          stop_runs = 0;
    int          rs_run = 0;
    bit          saw_dv = 1'b0;

    t05_sd_block_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_blocks  (num_blocks),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .read_en     (read_en),
        .read_stop   (read_stop),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .block_count (block_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always begin
        @(posedge clk);
        #1;
        data_ready = ($urandom_range(99, 0) < ready_pct);
    end

    // Monitor: consumes the scoreboard whenever the DUT hands over a byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) saw_dv = 1'b1;
            if (done) done_cnt++;
            if (read_stop) begin
                rs_run++;
            end else if (rs_run != 0) begin
                chk("read_stop_len", rs_run, 64);
                stop_runs++;
                rs_run = 0;
            end
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h expected none", data_out);
                end else begin
                    chk("data_out", data_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gated, input int gmin, input int gmax);
        int w;
        repeat ($urandom_range(gmax, gmin)) tick;
        if (gated) begin
            w = 0;
            while (!read_en && w < 3000) begin
                tick;
                w++;
            end
            if (w >= 3000) chk("read_en_wait", read_en, 1);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        tick;
        byte_valid = 1'b0;
    endtask

    task automatic start_xfer(input logic [15:0] n);
        start      = 1'b1;
        num_blocks = n;
        tick;
        start      = 1'b0;
    endtask

    task automatic send_crc;
        send_byte(8'($urandom), 1'b1, 0, 1);
        send_byte(8'($urandom), 1'b1, 0, 1);
    endtask

    task automatic finish_xfer(input int exp_blocks, input bit exp_error, input int runs0, input int done0);
        int w;
        w = 0;
        while (done_cnt == done0 && w < 5000) begin
            tick;
            w++;
        end
        if (w >= 5000) chk("done_wait", done, 1);
        chk("block_count", block_count, exp_blocks);
        chk("error", error, exp_error);
        chk("fifo_drained", exp_q.size(), 0);
        repeat (5) tick;
        chk("stop_runs", stop_runs - runs0, 1);
        chk("done_pulses", done_cnt - done0, 1);
        chk("busy_after", busy, 0);
    endtask

    task automatic run_xfer(input int nblk, input int ffgap, input int gmin, input int gmax,
                            input bit rnd);
        int runs0, done0;
        logic [7:0] v;
        runs0 = stop_runs;
        done0 = done_cnt;
        start_xfer(16'(nblk));
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < ffgap; k++) send_byte(8'hFF, 1'b1, gmin, gmax);
            send_byte(8'hFE, 1'b1, gmin, gmax);
            for (int i = 0; i < 512; i++) begin
                v = rnd ? 8'($urandom) : 8'(i);
                exp_q.push_back(v);
                send_byte(v, 1'b1, gmin, gmax);
            end
            send_crc();
        end
        finish_xfer(nblk, 1'b0, runs0, done0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read_en"}, read_en, 0);
        chk({tag, "_read_stop"}, read_stop, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_block_count"}, block_count, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int runs0, done0;
        rst = 1'b1;
        repeat (3) tick;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick;

        // Single block, incrementing payload, leading idle bytes.
        ready_pct = 100;
        runs0 = stop_runs;
        done0 = done_cnt;
        start_xfer(16'd1);
        send_byte(8'hFF, 1'b1, 0, 0);
        send_byte(8'hFF, 1'b1, 0, 0);
        send_byte(8'hFE, 1'b1, 0, 0);
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, 0, 0);
        end
        send_crc();
        finish_xfer(1, 1'b0, runs0, done0);

        // Three back-to-back blocks with idle fill between.
        run_xfer(3, 5, 0, 0, 1'b0);

        // Stalled consumer, slow byte source.
        ready_pct = 0;
        fork
            begin
                repeat (20) tick;
                ready_pct = 100;
            end
        join_none
        run_xfer(1, 1, 15, 15, 1'b0);

        // Token timeout: nothing reaches the output.
        ready_pct = 100;
        saw_dv = 1'b0;
        runs0 = stop_runs;
        done0 = done_cnt;
        start_xfer(16'd1);
        for (int i = 0; i < 255; i++) send_byte(8'hFF, 1'b1, 0, 0);
        finish_xfer(0, 1'b1, runs0, done0);
        chk("timeout_no_data", saw_dv, 0);

        // Forced overflow: ten pushes into an 8-deep FIFO with no consumer.
        ready_pct = 0;
        repeat (3) tick;
        runs0 = stop_runs;
        done0 = done_cnt;
        start_xfer(16'd1);
        send_byte(8'hFE, 1'b1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b0, 0, 0);
        end
        chk("overflow_error", error, 1);
        chk("overflow_count_full", data_valid, 1);
        ready_pct = 100;
        for (int i = 10; i < 512; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, 0, 0);
        end
        send_crc();
        finish_xfer(1, 1'b1, runs0, done0);

        // Randomized transfers under random backpressure.
        ready_pct = 70;
        for (int t = 0; t < 3; t++) begin
            run_xfer($urandom_range(2, 1), $urandom_range(8, 0), 0, 2, 1'b1);
        end

        // Reset in the middle of a payload.
        ready_pct = 100;
        runs0 = stop_runs;
        start_xfer(16'd2);
        send_byte(8'hFE, 1'b1, 0, 0);
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(8'(i + 7));
            send_byte(8'(i + 7), 1'b1, 0, 0);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_q.delete();
        chk_reset_outputs("midreset");
        repeat (80) tick;
        chk("midreset_no_stop", stop_runs - runs0, 0);

        // Zero-block request: done pulse only.
        done0 = done_cnt;
        start_xfer(16'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        tick;
        chk("zero_done_clear", done, 0);
        repeat (3) tick;
        chk("zero_done_pulses", done_cnt - done0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
